// File: rtl/subtractor_32bit_seq.sv
// Chunked subtractor diff = num1 - num2 - B_in, CHUNK bits per cycle; ovf port only with SUB_OVERFLOW_EN.
// Latency: out_valid rises WIDTH/CHUNK clocks after the accept edge; one operation in flight.
// Backpressure: result held in DONE until out_ready; in_ready low until then.
module subtractor_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             B_out,
  output logic             ovf
`else
  output logic             B_out
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("subtractor_32bit_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic [IW-1:0]     idx_q, idx_d;
`ifdef SUB_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0]  a_sl, b_sl;
  logic [CHUNK:0]    sub;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign B_out     = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    idx_d    = idx_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];
    // The extra top bit of the CHUNK+1 wide difference is the borrow out of the slice.
    sub  = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, borrow_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d      = num1;
          b_d      = num2;
          borrow_d = B_in;
          idx_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        diff_d[int'(idx_q)*CHUNK +: CHUNK] = sub[CHUNK-1:0];
        borrow_d = sub[CHUNK];
        if (idx_q == IW'(NCHUNK - 1)) begin
          bout_d  = sub[CHUNK];
`ifdef SUB_OVERFLOW_EN
          // Operand signs differ and the result sign differs from the minuend.
          ovf_d   = (a_sl[CHUNK-1] ^ b_sl[CHUNK-1]) & (a_sl[CHUNK-1] ^ sub[CHUNK-1]);
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      idx_q    <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      idx_q    <= idx_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// Bench for subtractor_32bit_seq: directed vector table, random ops against an arithmetic model,
// plus backpressure and mid-operation reset sequences.
module tb_subtractor_32bit_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             B_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             B_out;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subtractor_32bit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SUB_OVERFLOW_EN
    .B_out     (B_out),
    .ovf       (ovf)
`else
    .B_out     (B_out)
`endif
  );

  typedef struct {
    logic [31:0] n1;
    logic [31:0] n2;
    logic        bin;
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide arithmetic on the operand values.
  function automatic void model(input logic [31:0] n1, input logic [31:0] n2, input logic bin,
                                output logic [31:0] d, output logic bo, output logic ov);
    longint s;
    longint unsigned u1, u2;
    u1 = 64'(n1);
    u2 = 64'(n2) + 64'(bin);
    d  = n1 - n2 - 32'(bin);
    bo = (u1 < u2);
    s  = longint'($signed(n1)) - longint'($signed(n2)) - longint'(bin);
    ov = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
  endfunction

  task automatic wait_ready(input string name);
    int w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic wait_valid(input string name, output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 3 * NCHUNK) begin
      tick();
      cnt++;
    end
    chk({name, "_latency"}, 64'(cnt), 64'(NCHUNK));
  endtask

  task automatic op_check(input string name, input logic [31:0] n1, input logic [31:0] n2,
                          input logic bin, input logic [31:0] ed, input logic eb, input logic eo);
    int cnt;
    logic [31:0] held;
    wait_ready(name);
    num1 = n1; num2 = n2; B_in = bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    num1 = $urandom; num2 = $urandom; B_in = 1'($urandom);
    chk({name, "_busy_not_ready"}, 64'(in_ready), 64'd0);
    wait_valid(name, cnt);
    chk({name, "_diff"}, 64'(diff), 64'(ed));
    chk({name, "_bout"}, 64'(B_out), 64'(eb));
`ifdef SUB_OVERFLOW_EN
    chk({name, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in overflow expectation");
`endif
    held = diff;
    tick();
    chk({name, "_handshake"}, {62'd0, out_valid, in_ready}, 64'd1);
    chk({name, "_diff_kept"}, 64'(diff), 64'(held));
  endtask

  initial begin
    int cnt;
    bit ok;
    logic [31:0] rd;
    logic rb, ro;

    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h0000000B, 32'h00000001, 1'b1, 32'h00000009, 1'b0, 1'b0};
    vecs[2] = '{32'h00000010, 32'h00000020, 1'b0, 32'hFFFFFFF0, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[5] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[9] = '{32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    num1 = '0; num2 = '0; B_in = 1'b0;
    repeat (3) tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_diff", 64'(diff), 64'd0);
    chk("reset_bout", 64'(B_out), 64'd0);
`ifdef SUB_OVERFLOW_EN
    chk("reset_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      op_check($sformatf("vec%0d", i), vecs[i].n1, vecs[i].n2, vecs[i].bin,
               vecs[i].d, vecs[i].bo, vecs[i].ov);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic c;
      a = $urandom; b = $urandom; c = 1'($urandom);
      if (i % 8 == 0) b = a;
      model(a, b, c, rd, rb, ro);
      op_check($sformatf("rnd%0d", i), a, b, c, rd, rb, ro);
    end

    // Backpressure: result held, new request ignored until the output handshake.
    out_ready = 1'b0;
    wait_ready("bp");
    num1 = 32'h00000100; num2 = 32'h00000001; B_in = 1'b0; in_valid = 1'b1;
    tick();
    num1 = 32'h00000050; num2 = 32'h00000060; B_in = 1'b1;
    wait_valid("bp", cnt);
    chk("bp_diff", 64'(diff), 64'h000000FF);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(out_valid && !in_ready && diff == 32'h000000FF && !B_out)) ok = 1'b0;
    end
    chk("bp_hold", 64'(ok), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", {62'd0, out_valid, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accepted", 64'(in_ready), 64'd0);
    wait_valid("bp2", cnt);
    chk("bp2_diff", 64'(diff), 64'hFFFFFFEF);
    chk("bp2_bout", 64'(B_out), 64'd1);
    tick();

    // Reset two clocks after accept discards the operation.
    wait_ready("rs");
    num1 = 32'h00001234; num2 = 32'h00000005; B_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_diff", 64'(diff), 64'd0);
    chk("rs_bout", 64'(B_out), 64'd0);
    chk("rs_in_ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) ok = 1'b0;
    end
    chk("rs_no_pulse", 64'(ok), 64'd1);
    op_check("rs_next", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
